if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the fetch PC and drives the bus-master side of the instruction bus.
//  Produces the IF/ID pipeline register (if_pc, if_insn, if_en) that the decode stage and ID/EX register consume.
//  Obeys the same stall/flush pipeline control as the downstream stage registers; raises busy while a fetch is outstanding.
// PARAMETERS
//  WORD_ADDR_W   30     word-address width (PC, bus_addr, br_addr, new_pc)
//  WORD_DATA_W   32     instruction/data width
//  RESET_VECTOR  30'h0  first fetch address after reset
// PORTS
//  clk          in   1             clock; all state updates on posedge
//  reset        in   1             reset, synchronous, active-high
//  stall        in   1             hold PC, IF/ID register and hold buffer
//  flush        in   1             discard IF/ID contents; redirect PC to new_pc
//  new_pc       in   WORD_ADDR_W   flush target (exception/ERET vector)
//  br_taken     in   1             taken branch resolved in ID
//  br_addr      in   WORD_ADDR_W   branch target
//  busy         out  1             fetch not completing this cycle (to pipeline controller)
//  bus_req      out  1             arbiter request
//  bus_grnt     in   1             arbiter grant; held while bus_req is high
//  bus_as       out  1             address strobe, read-only access
//  bus_addr     out  WORD_ADDR_W   fetch address
//  bus_rd_data  in   WORD_DATA_W   instruction; valid when bus_rdy is high
//  bus_rdy      in   1             access complete, same cycle as data
//  if_pc        out  WORD_ADDR_W   PC of if_insn
//  if_insn      out  WORD_DATA_W   fetched instruction
//  if_en        out  1             IF/ID contents valid
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_VECTOR, if_pc=0, if_insn=ISA_NOP (32'h0), if_en=0,
//    br_pend=0, buf_vld=0. Comb outputs in IDLE: bus_req=0, bus_as=0, bus_addr=0, busy=1.
//  FSM:
//    IDLE   -> REQ unconditionally.
//    REQ    bus_req=1; on bus_grnt -> ACCESS.
//    ACCESS bus_req=1, bus_as=1, bus_addr=pc; done = bus_rdy.
//    HOLD   (IF_INSN_BUF_EN only) bus idle; buffered insn awaits stall release.
//  Completion (done & !stall & !flush):
//    if_pc<=pc, if_insn<=bus_rd_data, if_en<=1.
//    pc <= br_pend ? br_tgt : (br_taken ? br_addr : pc+1); br_pend<=0; stay in ACCESS.
//    1-cycle fetch throughput while bus_rdy is held.
//  ACCESS & !bus_rdy & !stall & !flush: IF/ID <= bubble (if_pc=0, if_insn=NOP, if_en=0); busy=1.
//  Branch while fetch incomplete (br_taken & !done & !stall): br_pend<=1, br_tgt<=br_addr.
//    The in-flight fetch is the delay slot and is delivered; the target is applied on its completion.
//  Priority, highest first: reset > stall > flush > completion/bubble.
//    Stall freezes pc, IF/ID, br_pend and the buffer, including when flush is also high.
//  Flush (no stall): pc<=new_pc, IF/ID<=bubble, br_pend<=0, buf_vld<=0, state->REQ.
//    An in-flight access is abandoned; bus_as is low for at least one cycle.
//  pc+1 wraps modulo 2^WORD_ADDR_W (all-ones -> 0), no flag.
//  busy = !(state==ACCESS & bus_rdy) & !(state==HOLD).
// CONFIGURATION
//  IF_INSN_BUF_EN defined:
//    bus_rdy during stall -> capture {pc, bus_rd_data} into the hold buffer, buf_vld=1, state HOLD
//      (bus_req=0, bus_as=0).
//    On the first cycle with !stall: IF/ID loads the buffer, pc advances per the completion rule, buf_vld=0,
//      state -> REQ. Flush in HOLD drops the buffer.
//  IF_INSN_BUF_EN undefined:
//    bus_rdy during stall is ignored; state stays ACCESS with bus_as=1 at the same pc.
//    The word is re-read after the stall releases. No HOLD state.
// STRUCTURE
//  Shared header (cpu.h / isa.h): IF_ST_IDLE/REQ/ACCESS/HOLD 2-bit encodings, ISA_NOP,
//    WORD_ADDR_W/WORD_DATA_W.
//  Sub-module if_hold_buf: 1-entry buffer (vld, pc, insn); instantiated only under IF_INSN_BUF_EN.
//  Top level: FSM, pc/br_pend registers, IF/ID register.
// TESTING
//  1 Reset release, bus_grnt=1 and bus_rdy tied 1, mem[i]=i+100 ->
//    IF/ID shows (pc 0, 100), (1, 101), (2, 102) on consecutive cycles; first if_en=1 at cycle 3.
//  2 Grant withheld 4 cycles after REQ -> bus_req=1, bus_as=0 throughout, busy=1, if_en=0 bubbles;
//    first fetch at addr 0 on the grant+1 cycle.
//  3 bus_rdy low 3 cycles at pc=5, br_taken=1 br_addr=0x40 in the first of them ->
//    insn@5 delivered (delay slot), next bus_addr=0x40.
//  4 Stall 2 cycles with bus_rdy=1 at pc=8 -> IF/ID frozen.
//    BUF_EN: bus_as=0 during HOLD, insn@8 in IF/ID the cycle after release, no re-read.
//    No BUF_EN: addr 8 re-read after release.
//  5 flush=1 new_pc=0x100 during an incomplete access at pc=9 -> bus_as low for 1 cycle, if_en=0,
//    next fetch at 0x100. flush+stall together -> no change until stall drops.
//  6 pc=30'h3FFF_FFFF completes -> next bus_addr=0. Reset asserted mid-ACCESS -> all reset values next cycle.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU definitions for the instruction-fetch stage.
// Fetch FSM encodings, NOP encoding and default bus widths.
package if_fetch_unit_pkg;

  localparam int CPU_ADDR_W = 30;
  localparam int CPU_DATA_W = 32;

  localparam logic [CPU_DATA_W-1:0] ISA_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_ST_IDLE   = 2'd0,
    IF_ST_REQ    = 2'd1,
    IF_ST_ACCESS = 2'd2,
    IF_ST_HOLD   = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_fetch_unit_hold_buf.sv
// One-entry hold buffer for a word returned while the pipe is stalled.
// Only instantiated when IF_INSN_BUF_EN is defined.
module if_fetch_unit_hold_buf
  import if_fetch_unit_pkg::*;
#(
  parameter int WORD_ADDR_W = CPU_ADDR_W,
  parameter int WORD_DATA_W = CPU_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap,
  input  logic                   clr,
  input  logic [WORD_ADDR_W-1:0] pc_in,
  input  logic [WORD_DATA_W-1:0] insn_in,
  output logic                   vld,
  output logic [WORD_ADDR_W-1:0] pc,
  output logic [WORD_DATA_W-1:0] insn
);

  // Capture on stall-time completion, drop on release or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= 1'b0;
      pc   <= '0;
      insn <= WORD_DATA_W'(ISA_NOP);
    end else if (clr) begin
      vld  <= 1'b0;
    end else if (cap) begin
      vld  <= 1'b1;
      pc   <= pc_in;
      insn <= insn_in;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, bus master FSM, IF/ID register.
// Define IF_INSN_BUF_EN to keep words returned during a stall.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                     WORD_ADDR_W  = CPU_ADDR_W,
  parameter int                     WORD_DATA_W  = CPU_DATA_W,
  parameter logic [WORD_ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] new_pc,
  input  logic                   br_taken,
  input  logic [WORD_ADDR_W-1:0] br_addr,
  output logic                   busy,
  output logic                   bus_req,
  input  logic                   bus_grnt,
  output logic                   bus_as,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy,
  output logic [WORD_ADDR_W-1:0] if_pc,
  output logic [WORD_DATA_W-1:0] if_insn,
  output logic                   if_en
);

  localparam logic [WORD_DATA_W-1:0] NOP = WORD_DATA_W'(ISA_NOP);

  if_state_e              state;
  if_state_e              state_nx;
  logic [WORD_ADDR_W-1:0] pc;
  logic [WORD_ADDR_W-1:0] pc_nx;
  logic                   br_pend;
  logic [WORD_ADDR_W-1:0] br_tgt;
  logic                   done;
  logic                   buf_rel;
  logic                   adv;
  logic                   buf_vld;
  logic [WORD_ADDR_W-1:0] buf_pc;
  logic [WORD_DATA_W-1:0] buf_insn;

`ifdef IF_INSN_BUF_EN
  logic buf_cap;
  logic buf_clr;

  assign buf_cap = (state == IF_ST_ACCESS) && bus_rdy && stall;
  assign buf_clr = !stall && (flush || buf_rel);

  if_fetch_unit_hold_buf #(
    .WORD_ADDR_W (WORD_ADDR_W),
    .WORD_DATA_W (WORD_DATA_W)
  ) u_if_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .cap     (buf_cap),
    .clr     (buf_clr),
    .pc_in   (pc),
    .insn_in (bus_rd_data),
    .vld     (buf_vld),
    .pc      (buf_pc),
    .insn    (buf_insn)
  );
`else
  assign buf_vld  = 1'b0;
  assign buf_pc   = '0;
  assign buf_insn = NOP;
`endif

  assign buf_rel = (state == IF_ST_HOLD) && !stall;
  assign adv     = !stall && !flush && (done || buf_rel);
  assign busy    = !((state == IF_ST_ACCESS) && bus_rdy)
                && !(state == IF_ST_HOLD);

  // Pending branch target wins over a branch resolved this cycle.
  assign pc_nx = br_pend  ? br_tgt  :
                 br_taken ? br_addr :
                 pc + WORD_ADDR_W'(1);

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IF_ST_IDLE;
    else       state <= state_nx;
  end

  // Next state and bus-side outputs; flush overrides unless stalled.
  always_comb begin
    state_nx = state;
    bus_req  = 1'b0;
    bus_as   = 1'b0;
    bus_addr = '0;
    done     = 1'b0;
    unique case (state)
      IF_ST_IDLE: state_nx = IF_ST_REQ;
      IF_ST_REQ: begin
        bus_req = 1'b1;
        if (bus_grnt) state_nx = IF_ST_ACCESS;
      end
      IF_ST_ACCESS: begin
        bus_req  = 1'b1;
        bus_as   = 1'b1;
        bus_addr = pc;
        done     = bus_rdy;
`ifdef IF_INSN_BUF_EN
        if (bus_rdy && stall) state_nx = IF_ST_HOLD;
`endif
      end
`ifdef IF_INSN_BUF_EN
      IF_ST_HOLD: begin
        if (!stall) state_nx = IF_ST_REQ;
      end
`else
      default: state_nx = IF_ST_IDLE;
`endif
    endcase
    if (!stall && flush) state_nx = IF_ST_REQ;
  end

  // PC, branch-pending and IF/ID register; stall freezes all of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      br_pend <= 1'b0;
      br_tgt  <= '0;
      if_pc   <= '0;
      if_insn <= NOP;
      if_en   <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        pc      <= new_pc;
        br_pend <= 1'b0;
        if_pc   <= '0;
        if_insn <= NOP;
        if_en   <= 1'b0;
      end else if (adv) begin
        pc      <= pc_nx;
        br_pend <= 1'b0;
        if_pc   <= buf_rel ? buf_pc : pc;
        if_insn <= buf_rel ? buf_insn : bus_rd_data;
        if_en   <= buf_rel ? buf_vld : 1'b1;
      end else begin
        if_pc   <= '0;
        if_insn <= NOP;
        if_en   <= 1'b0;
        if (br_taken) begin
          br_pend <= 1'b1;
          br_tgt  <= br_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus
// a randomized run checked against a delivery-order reference model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;
  logic        br_taken;
  logic [29:0] br_addr;
  logic        busy;
  logic        bus_req;
  logic        bus_grnt;
  logic        bus_as;
  logic [29:0] bus_addr;
  logic [31:0] bus_rd_data;
  logic        bus_rdy;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .br_taken    (br_taken),
    .br_addr     (br_addr),
    .busy        (busy),
    .bus_req     (bus_req),
    .bus_grnt    (bus_grnt),
    .bus_as      (bus_as),
    .bus_addr    (bus_addr),
    .bus_rd_data (bus_rd_data),
    .bus_rdy     (bus_rdy),
    .if_pc       (if_pc),
    .if_insn     (if_insn),
    .if_en       (if_en)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [29:0] a);
    return 32'(a) + 32'd100;
  endfunction

  always_comb bus_rd_data = mem(bus_addr);

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    new_pc   = '0;
    br_taken = 1'b0;
    br_addr  = '0;
    bus_grnt = 1'b1;
    bus_rdy  = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_addr(input logic [29:0] a);
    int n;
    n = 0;
    while (!(bus_as && bus_addr == a) && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!(bus_as && bus_addr == a)) begin
      errors++;
      $display("FAIL wait_addr: bus_addr=%h as=%b never reached %h",
               bus_addr, bus_as, a);
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({if_en, if_pc, if_insn} !== {1'b0, 30'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_ifid: en=%b pc=%h insn=%h required 0/0/0",
               if_en, if_pc, if_insn);
    end
    checks++;
    if ({bus_req, bus_as, bus_addr, busy} !== {1'b0, 1'b0, 30'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_bus: req=%b as=%b addr=%h busy=%b required 0 0 0 1",
               bus_req, bus_as, bus_addr, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    step();
    checks++;
    if (if_en !== 1'b0 || bus_req !== 1'b1) begin
      errors++;
      $display("FAIL stream_c1: en=%b req=%b required 0 1", if_en, bus_req);
    end
    step();
    checks++;
    if (if_en !== 1'b0 || bus_as !== 1'b1 || bus_addr !== 30'h0) begin
      errors++;
      $display("FAIL stream_c2: en=%b as=%b addr=%h required 0 1 0",
               if_en, bus_as, bus_addr);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (if_en !== 1'b1 || if_pc !== 30'(k) || if_insn !== 32'(k + 100)) begin
        errors++;
        $display("FAIL stream_%0d: en=%b pc=%h insn=%h required 1 %h %h",
                 k, if_en, if_pc, if_insn, k, k + 100);
      end
    end
  endtask

  task automatic test_grant();
    do_reset();
    bus_grnt = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus_req !== 1'b1 || bus_as !== 1'b0 || busy !== 1'b1 || if_en !== 1'b0) begin
        errors++;
        $display("FAIL grant_wait_%0d: req=%b as=%b busy=%b en=%b required 1 0 1 0",
                 k, bus_req, bus_as, busy, if_en);
      end
    end
    bus_grnt = 1'b1;
    step();
    checks++;
    if (bus_as !== 1'b1 || bus_addr !== 30'h0) begin
      errors++;
      $display("FAIL grant_access: as=%b addr=%h required 1 0", bus_as, bus_addr);
    end
    step();
    checks++;
    if (if_en !== 1'b1 || if_pc !== 30'h0 || if_insn !== 32'd100) begin
      errors++;
      $display("FAIL grant_first: en=%b pc=%h insn=%h required 1 0 64",
               if_en, if_pc, if_insn);
    end
  endtask

  task automatic test_branch();
    do_reset();
    wait_addr(30'd5);
    bus_rdy  = 1'b0;
    br_taken = 1'b1;
    br_addr  = 30'h40;
    step();
    br_taken = 1'b0;
    checks++;
    if (if_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL branch_bubble: en=%b busy=%b required 0 1", if_en, busy);
    end
    step();
    step();
    checks++;
    if (bus_addr !== 30'd5) begin
      errors++;
      $display("FAIL branch_hold_addr: addr=%h required 5", bus_addr);
    end
    bus_rdy = 1'b1;
    step();
    checks++;
    if (if_pc !== 30'd5 || if_insn !== 32'd105 || bus_addr !== 30'h40) begin
      errors++;
      $display("FAIL branch_slot: pc=%h insn=%h addr=%h required 5 69 40",
               if_pc, if_insn, bus_addr);
    end
    step();
    checks++;
    if (if_pc !== 30'h40 || if_insn !== 32'h40 + 32'd100) begin
      errors++;
      $display("FAIL branch_target: pc=%h insn=%h required 40 a4", if_pc, if_insn);
    end
  endtask

  task automatic test_stall();
    do_reset();
    wait_addr(30'd8);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (if_pc !== 30'd7 || if_en !== 1'b1 || if_insn !== 32'd107) begin
        errors++;
        $display("FAIL stall_frozen_%0d: pc=%h en=%b insn=%h required 7 1 6b",
                 k, if_pc, if_en, if_insn);
      end
`ifdef IF_INSN_BUF_EN
      checks++;
      if (bus_as !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_as_%0d: as=%b required 0", k, bus_as);
      end
`else
      checks++;
      if (bus_as !== 1'b1 || bus_addr !== 30'd8) begin
        errors++;
        $display("FAIL stall_access_%0d: as=%b addr=%h required 1 8",
                 k, bus_as, bus_addr);
      end
`endif
    end
    stall = 1'b0;
    step();
    checks++;
    if (if_pc !== 30'd8 || if_insn !== 32'd108 || if_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: pc=%h insn=%h en=%b required 8 6c 1",
               if_pc, if_insn, if_en);
    end
`ifdef IF_INSN_BUF_EN
    step();
`endif
    checks++;
    if (bus_as !== 1'b1 || bus_addr !== 30'd9) begin
      errors++;
      $display("FAIL stall_next: as=%b addr=%h required 1 9", bus_as, bus_addr);
    end
  endtask

  task automatic test_flush();
    do_reset();
    wait_addr(30'd9);
    bus_rdy = 1'b0;
    step();
    flush  = 1'b1;
    new_pc = 30'h100;
    step();
    flush = 1'b0;
    checks++;
    if (bus_as !== 1'b0 || if_en !== 1'b0 || bus_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_abandon: as=%b en=%b req=%b required 0 0 1",
               bus_as, if_en, bus_req);
    end
    bus_rdy = 1'b1;
    step();
    checks++;
    if (bus_as !== 1'b1 || bus_addr !== 30'h100) begin
      errors++;
      $display("FAIL flush_target: as=%b addr=%h required 1 100", bus_as, bus_addr);
    end
    step();
    checks++;
    if (if_en !== 1'b1 || if_pc !== 30'h100) begin
      errors++;
      $display("FAIL flush_deliver: en=%b pc=%h required 1 100", if_en, if_pc);
    end
    flush  = 1'b1;
    stall  = 1'b1;
    new_pc = 30'h200;
    step();
    step();
    checks++;
    if (if_en !== 1'b1 || if_pc !== 30'h100) begin
      errors++;
      $display("FAIL flush_stall_frozen: en=%b pc=%h required 1 100", if_en, if_pc);
    end
    flush = 1'b0;
    stall = 1'b0;
    step();
    checks++;
    if (if_en !== 1'b1 || if_pc !== 30'h101) begin
      errors++;
      $display("FAIL flush_stall_release: en=%b pc=%h required 1 101", if_en, if_pc);
    end
`ifdef IF_INSN_BUF_EN
    step();
`endif
    checks++;
    if (bus_addr !== 30'h102) begin
      errors++;
      $display("FAIL flush_stall_next: addr=%h required 102", bus_addr);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    step();
    step();
    flush  = 1'b1;
    new_pc = 30'h3FFF_FFFF;
    step();
    flush = 1'b0;
    step();
    checks++;
    if (bus_as !== 1'b1 || bus_addr !== 30'h3FFF_FFFF) begin
      errors++;
      $display("FAIL wrap_access: as=%b addr=%h required 1 3fffffff", bus_as, bus_addr);
    end
    step();
    checks++;
    if (if_pc !== 30'h3FFF_FFFF || if_insn !== 32'h4000_0063 || bus_addr !== 30'h0) begin
      errors++;
      $display("FAIL wrap_next: pc=%h insn=%h addr=%h required 3fffffff 40000063 0",
               if_pc, if_insn, bus_addr);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({if_en, if_pc, if_insn, bus_req, bus_as, bus_addr, busy}
        !== {1'b0, 30'h0, 32'h0, 1'b0, 1'b0, 30'h0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset: en=%b pc=%h insn=%h req=%b as=%b addr=%h busy=%b",
               if_en, if_pc, if_insn, bus_req, bus_as, bus_addr, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [29:0] exp_pc;
    logic [29:0] pend_tgt;
    bit          pend_v;
    int          ndel;
    do_reset();
    exp_pc = '0;
    pend_v = 1'b0;
    pend_tgt = '0;
    ndel   = 0;
    for (int c = 0; c < 800; c++) begin
      stall    = ($urandom_range(0, 4) == 0);
      bus_rdy  = ($urandom_range(0, 3) != 0);
      bus_grnt = ($urandom_range(0, 1) == 1);
      br_taken = !pend_v && ($urandom_range(0, 11) == 0);
      br_addr  = 30'($urandom_range(0, 4095));
      step();
      if (!stall && if_en) begin
        checks++;
        if (if_pc !== exp_pc || if_insn !== mem(exp_pc)) begin
          errors++;
          $display("FAIL random_deliver_%0d: pc=%h insn=%h required %h %h",
                   ndel, if_pc, if_insn, exp_pc, mem(exp_pc));
        end
        exp_pc = pend_v ? pend_tgt : (br_taken ? br_addr : exp_pc + 30'd1);
        pend_v = 1'b0;
        ndel++;
      end else if (!stall && br_taken) begin
        pend_v   = 1'b1;
        pend_tgt = br_addr;
      end
    end
    br_taken = 1'b0;
    stall    = 1'b0;
    checks++;
    if (ndel < 150) begin
      errors++;
      $display("FAIL random_progress: deliveries=%0d required >=150", ndel);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_grant();
    test_branch();
    test_stall();
    test_flush();
    test_wrap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
